// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front-end: data widths,
// the default de-scramble mask, the assembly FSM encoding and the opcode
// values shared with the compute unit.
package fetch_pkg;

    localparam int INSTR_W = 16;
    localparam int BYTE_W  = 8;

    localparam logic [INSTR_W-1:0] DEFAULT_MASK = 16'hAAAF;

    // Assembly FSM encoding
    localparam logic [0:0] ST_HI = 1'b0;  // awaiting high byte
    localparam logic [0:0] ST_LO = 1'b1;  // high byte held, awaiting low byte

    // Opcodes understood by the compute unit
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LOAD = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;

    // Joins a high/low byte pair into one instruction word.
    function automatic logic [INSTR_W-1:0] join_bytes(
        input logic [BYTE_W-1:0] hi,
        input logic [BYTE_W-1:0] lo
    );
        return {hi, lo};
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous show-ahead FIFO: the head word is visible on rdata_o whenever
// valid_o is high (and reads as zero otherwise). flush_i wins over push/pop.
module instr_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = INSTR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_push, do_pop;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;

    assign do_push = push_i & ~flush_i & ~full_o;
    assign do_pop  = pop_i  & ~flush_i & valid_o;

    // Next-state for pointers and occupancy; pointers wrap naturally (DEPTH is 2^n)
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write port
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately left unreset; valid_o masks stale contents.
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: assembles 16-bit words from a high-byte-first
// byte stream, optionally XOR de-scrambles them and queues them for the
// compute unit. Define DESCRAMBLE_EN to store {hi,lo} ^ MASK instead of
// the raw word.
module instr_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int               DEPTH = 4,
    parameter logic [INSTR_W-1:0] MASK = DEFAULT_MASK
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic [BYTE_W-1:0]      byte_in,
    input  logic                   byte_valid,
    output logic                   byte_ready,
    output logic [INSTR_W-1:0]     instr_out,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drop_err
);

`ifdef DESCRAMBLE_EN
    localparam bit DESCRAMBLE = 1'b1;
`else
    localparam bit DESCRAMBLE = 1'b0;
`endif
    // Zero mask when de-scrambling is compiled out, so the XOR is a no-op.
    localparam logic [INSTR_W-1:0] XOR_MASK = MASK & {INSTR_W{DESCRAMBLE}};

    logic [0:0]        state_q, state_d;
    logic [BYTE_W-1:0] hi_q, hi_d;
    logic              drop_q, drop_d;
    logic              fifo_full;
    logic              accept, push;
    logic [INSTR_W-1:0] word;

    // byte_ready is purely a function of registered state, ena and rst;
    // it never looks at instr_ready, so a pop does not ripple back here.
    assign byte_ready = ~rst & ena & ((state_q == ST_HI) | ~fifo_full);
    assign accept     = byte_valid & byte_ready;
    assign push       = accept & (state_q == ST_LO) & ~flush;
    assign word       = join_bytes(hi_q, byte_in) ^ XOR_MASK;
    assign drop_err   = drop_q;

    // Assembly FSM next-state and sticky overflow flag
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        drop_d  = drop_q | (ena & byte_valid & ~byte_ready);
        if (flush) begin
            state_d = ST_HI;
            hi_d    = '0;
        end else if (accept) begin
            if (state_q == ST_HI) begin
                hi_d    = byte_in;
                state_d = ST_LO;
            end else begin
                state_d = ST_HI;
            end
        end
    end

    // FSM, held high byte and drop flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_HI;
            hi_q    <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            drop_q  <= drop_d;
        end
    end

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (word),
        .pop_i   (instr_ready),
        .flush_i (flush),
        .rdata_o (instr_out),
        .valid_o (instr_valid),
        .full_o  (fifo_full),
        .count_o (count)
    );

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer (DEPTH=4). Expected words carry
// both raw and de-scrambled values; the column used follows DESCRAMBLE_EN.
module tb_instr_fetch_buffer;

`ifdef DESCRAMBLE_EN
    localparam bit DESCR = 1'b1;
`else
    localparam bit DESCR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        flush;
    logic [2:0]  count;
    logic        drop_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] raw;
        logic [15:0] scr;
    } vec_t;

    vec_t vecs[6];

    instr_fetch_buffer #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .flush       (flush),
        .count       (count),
        .drop_err    (drop_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pick(input logic [15:0] raw, input logic [15:0] scr);
        return DESCR ? scr : raw;
    endfunction

    function automatic logic [15:0] expw(input int i);
        return pick(vecs[i].raw, vecs[i].scr);
    endfunction

    task automatic send_word(input logic [7:0] hi, input logic [7:0] lo);
        byte_valid = 1'b1;
        byte_in    = hi;
        tick();
        byte_in    = lo;
        tick();
        byte_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{hi: 8'hBB, lo: 8'hA5, raw: 16'hBBA5, scr: 16'h110A};
        vecs[1] = '{hi: 8'h00, lo: 8'h00, raw: 16'h0000, scr: 16'hAAAF};
        vecs[2] = '{hi: 8'hFF, lo: 8'hFF, raw: 16'hFFFF, scr: 16'h5550};
        vecs[3] = '{hi: 8'h12, lo: 8'h34, raw: 16'h1234, scr: 16'hB89B};
        vecs[4] = '{hi: 8'h5A, lo: 8'h0F, raw: 16'h5A0F, scr: 16'hF0A0};
        vecs[5] = '{hi: 8'h01, lo: 8'h02, raw: 16'h0102, scr: 16'hABAD};

        rst = 1'b1; ena = 1'b1; byte_in = '0; byte_valid = 1'b0;
        instr_ready = 1'b0; flush = 1'b0;
        #1;
        check("rst_count", 32'(count), 0);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_out", 32'(instr_out), 0);
        check("rst_byte_ready", 32'(byte_ready), 0);
        check("rst_drop_err", 32'(drop_err), 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_byte_ready", 32'(byte_ready), 1);

        // Table: one word each, checked one cycle after the low byte, then popped
        for (int i = 0; i < 6; i++) begin
            send_word(vecs[i].hi, vecs[i].lo);
            check($sformatf("vec%0d_valid", i), 32'(instr_valid), 1);
            check($sformatf("vec%0d_out", i), 32'(instr_out), 32'(expw(i)));
            check($sformatf("vec%0d_count", i), 32'(count), 1);
            instr_ready = 1'b1;
            tick();
            instr_ready = 1'b0;
            check($sformatf("vec%0d_count_after_pop", i), 32'(count), 0);
            check($sformatf("vec%0d_out_empty", i), 32'(instr_out), 0);
        end

        // ena gating with one word buffered
        send_word(vecs[3].hi, vecs[3].lo);
        ena = 1'b0; byte_valid = 1'b1; byte_in = 8'h55;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ena0_byte_ready", 32'(byte_ready), 0);
            tick();
        end
        check("ena0_drop_err", 32'(drop_err), 0);
        check("ena0_count", 32'(count), 1);
        byte_valid = 1'b0;
        instr_ready = 1'b1;
        #1;
        check("ena0_pop_out", 32'(instr_out), 32'(expw(3)));
        tick();
        instr_ready = 1'b0;
        check("ena0_pop_count", 32'(count), 0);
        ena = 1'b1;
        send_word(vecs[4].hi, vecs[4].lo);
        check("ena0_fsm_hi_word", 32'(instr_out), 32'(expw(4)));
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;

        // Flush after a buffered word and a lone high byte
        send_word(vecs[5].hi, vecs[5].lo);
        byte_valid = 1'b1; byte_in = 8'h99;
        tick();
        byte_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_count", 32'(count), 0);
        check("flush_valid", 32'(instr_valid), 0);
        send_word(8'h12, 8'h34);
        check("flush_next_word", 32'(instr_out), 32'(pick(16'h1234, 16'hB89B)));
        check("flush_next_count", 32'(count), 1);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;

        // Simultaneous push and pop at count=2
        send_word(vecs[5].hi, vecs[5].lo);
        send_word(vecs[4].hi, vecs[4].lo);
        check("pp_count_pre", 32'(count), 2);
        byte_valid = 1'b1; byte_in = vecs[2].hi;
        tick();
        byte_in = vecs[2].lo; instr_ready = 1'b1;
        tick();
        byte_valid = 1'b0;
        check("pp_count_same", 32'(count), 2);
        check("pp_head_b", 32'(instr_out), 32'(expw(4)));
        tick();
        check("pp_head_c", 32'(instr_out), 32'(expw(2)));
        tick();
        instr_ready = 1'b0;
        check("pp_drained", 32'(count), 0);

        // Fill and overflow
        for (int i = 0; i < 4; i++) send_word(vecs[i].hi, vecs[i].lo);
        check("fill_count", 32'(count), 4);
        byte_valid = 1'b1; byte_in = 8'h77;
        #1;
        check("ovf_hi_ready", 32'(byte_ready), 1);
        tick();
        byte_in = 8'h88;
        #1;
        check("ovf_lo_ready", 32'(byte_ready), 0);
        tick();
        byte_valid = 1'b0;
        check("ovf_drop_err", 32'(drop_err), 1);
        check("ovf_count", 32'(count), 4);
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d_out", i), 32'(instr_out), 32'(expw(i)));
            tick();
            if (i == 0) check("drain_ready_lo", 32'(byte_ready), 1);
        end
        instr_ready = 1'b0;
        check("drain_count", 32'(count), 0);
        byte_valid = 1'b1; byte_in = 8'h66;
        tick();
        byte_valid = 1'b0;
        check("ovf_fifth_word", 32'(instr_out), 32'(pick(16'h7766, 16'hDDC9)));
        check("ovf_drop_sticky", 32'(drop_err), 1);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;

        // Asynchronous reset mid-stream with 2 words buffered and a high byte held
        send_word(vecs[0].hi, vecs[0].lo);
        send_word(vecs[1].hi, vecs[1].lo);
        byte_valid = 1'b1; byte_in = 8'hC3;
        tick();
        byte_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", 32'(count), 0);
        check("arst_valid", 32'(instr_valid), 0);
        check("arst_out", 32'(instr_out), 0);
        check("arst_drop_err", 32'(drop_err), 0);
        #2;
        rst = 1'b0;
        tick();
        send_word(8'h12, 8'h34);
        check("arst_fsm_hi_word", 32'(instr_out), 32'(pick(16'h1234, 16'hB89B)));
        check("arst_count_after", 32'(count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
